// File: rtl/mmu_utlb_pkg.sv
// Shared MMU definitions: main-TLB result, direct-map window and micro-TLB entry.
package mmu_utlb_pkg;

   localparam int PS_4K = 12;
   localparam int PS_4M = 21;

   typedef struct packed {
      logic        found;
      logic [19:0] ppn;
      logic [5:0]  ps;
      logic        v;
      logic        d;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        g;
   } tlb_result_t;

   typedef struct packed {
      logic       plv0;
      logic       plv3;
      logic [1:0] mat;
      logic [2:0] pseg;
      logic [2:0] vseg;
   } dmw_t;

   // odd is only meaningful for 4 KB pages; huge pages ignore va[21:12]
   typedef struct packed {
      logic        valid;
      logic [18:0] vppn;
      logic        odd;
      logic        huge;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn;
      logic        v;
      logic        d;
      logic [1:0]  plv;
      logic [1:0]  mat;
   } utlb_entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} utlb_state_t;

endpackage

// File: rtl/mmu_utlb_if.sv
// Lookup channel and main-TLB refill channel of one micro-TLB.
// slave = micro-TLB side, master = requester / main-TLB arbiter side.
interface mmu_utlb_if;
   logic        lk_valid;
   logic [31:0] lk_va;
   logic        lk_done;
   logic        lk_found;
   logic [31:0] lk_pa;
   logic        lk_v;
   logic        lk_d;
   logic [1:0]  lk_plv;
   logic [1:0]  lk_mat;

   logic        rf_req;
   logic [18:0] rf_vppn;
   logic        rf_va_bit12;
   logic [9:0]  rf_asid;
   logic        rf_gnt;
   logic        rf_rvalid;
   logic        rf_found;
   logic [19:0] rf_ppn;
   logic [5:0]  rf_ps;
   logic        rf_v;
   logic        rf_d;
   logic [1:0]  rf_plv;
   logic [1:0]  rf_mat;
   logic        rf_g;

   modport slave (
      input  lk_valid, lk_va,
      output lk_done, lk_found, lk_pa, lk_v, lk_d, lk_plv, lk_mat,
      output rf_req, rf_vppn, rf_va_bit12, rf_asid,
      input  rf_gnt, rf_rvalid, rf_found, rf_ppn, rf_ps, rf_v, rf_d, rf_plv, rf_mat, rf_g
   );

   modport master (
      output lk_valid, lk_va,
      input  lk_done, lk_found, lk_pa, lk_v, lk_d, lk_plv, lk_mat,
      input  rf_req, rf_vppn, rf_va_bit12, rf_asid,
      output rf_gnt, rf_rvalid, rf_found, rf_ppn, rf_ps, rf_v, rf_d, rf_plv, rf_mat, rf_g
   );
endinterface

// File: rtl/mmu_utlb_match.sv
// Fully-associative compare of one VA/ASID against all micro-TLB entries.
module mmu_utlb_match
   import mmu_utlb_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int IDXW    = $clog2(ENTRIES)
) (
   input  utlb_entry_t [ENTRIES-1:0] ents,
   input  logic [31:0]               va,
   input  logic [9:0]                asid,
   output logic                      hit,
   output logic [IDXW-1:0]           idx
);

   logic [ENTRIES-1:0] m;

   // per-entry match: global or same ASID, then huge or 4 KB tag compare
   always_comb begin
      m = '0;
      for (int i = 0; i < ENTRIES; i++)
         m[i] = ents[i].valid && (ents[i].g || ents[i].asid == asid) &&
                (ents[i].huge ? (va[31:22] == ents[i].vppn[18:9])
                              : (va[31:13] == ents[i].vppn && va[12] == ents[i].odd));
   end

   // priority encode, lowest index wins
   always_comb begin
      hit = |m;
      idx = '0;
      for (int i = ENTRIES-1; i >= 0; i--)
         if (m[i]) idx = IDXW'(i);
   end

endmodule

// File: rtl/mmu_utlb.sv
// Micro-TLB: same-cycle hit translation, refill from the main TLB on miss.
module mmu_utlb
   import mmu_utlb_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int IDXW    = $clog2(ENTRIES)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic [9:0] asid,
   mmu_utlb_if.slave  bus
);

   utlb_entry_t [ENTRIES-1:0] ents;
   utlb_entry_t               hent;
   utlb_entry_t               new_ent;
   utlb_state_t               state, nstate;
   logic                      drop;
   logic [IDXW-1:0]           rr_ptr;
   logic [IDXW-1:0]           victim;
   logic                      full;
   logic [31:12]              lat_va;
   logic [9:0]                lat_asid;
   logic                      hit;
   logic [IDXW-1:0]           hit_idx;
   logic                      idle_hit, idle_miss, rv_live, install, miss_done;

   mmu_utlb_match #(.ENTRIES(ENTRIES), .IDXW(IDXW)) u_match (
      .ents (ents),
      .va   (bus.lk_va),
      .asid (asid),
      .hit  (hit),
      .idx  (hit_idx)
   );

   assign hent      = ents[hit_idx];
   assign idle_hit  = (state == ST_IDLE) && bus.lk_valid && hit;
   assign idle_miss = (state == ST_IDLE) && bus.lk_valid && !hit;
   // a flush coinciding with the response also kills it
   assign rv_live   = (state == ST_WAIT) && bus.rf_rvalid && !drop && !flush;
   assign install   = rv_live && bus.rf_found;
   // an abandoned lookup still gets its entry installed but never a done
   assign miss_done = rv_live && !bus.rf_found && bus.lk_valid;

   assign bus.rf_vppn     = lat_va[31:13];
   assign bus.rf_va_bit12 = lat_va[12];
   assign bus.rf_asid     = lat_asid;

   // lookup result; everything stays zero unless lk_done
   always_comb begin
      bus.lk_done  = 1'b0;
      bus.lk_found = 1'b0;
      bus.lk_pa    = '0;
      bus.lk_v     = 1'b0;
      bus.lk_d     = 1'b0;
      bus.lk_plv   = '0;
      bus.lk_mat   = '0;
      if (idle_hit) begin
         bus.lk_done  = 1'b1;
         bus.lk_found = 1'b1;
         bus.lk_pa    = hent.huge ? {hent.ppn[19:9], bus.lk_va[20:0]}
                                  : {hent.ppn, bus.lk_va[11:0]};
         bus.lk_v     = hent.v;
         bus.lk_d     = hent.d;
         bus.lk_plv   = hent.plv;
         bus.lk_mat   = hent.mat;
      end else if (miss_done) begin
         bus.lk_done  = 1'b1;
      end
   end

   // refill FSM next state and request
   always_comb begin
      nstate     = state;
      bus.rf_req = 1'b0;
      case (state)
         ST_IDLE: if (idle_miss) nstate = ST_REQ;
         ST_REQ: begin
            bus.rf_req = 1'b1;
            if (bus.rf_gnt) nstate = ST_WAIT;
         end
         ST_WAIT: if (bus.rf_rvalid) nstate = ST_IDLE;
         default: nstate = ST_IDLE;
      endcase
   end

   // victim: lowest free slot, else the round-robin pointer
   always_comb begin
      full   = 1'b1;
      victim = rr_ptr;
      for (int i = ENTRIES-1; i >= 0; i--)
         if (!ents[i].valid) begin
            full   = 1'b0;
            victim = IDXW'(i);
         end
   end

   // entry image built from the latched request and the main-TLB result
   always_comb begin
      new_ent       = '0;
      new_ent.valid = 1'b1;
      new_ent.vppn  = lat_va[31:13];
      new_ent.odd   = lat_va[12];
      new_ent.huge  = (bus.rf_ps == 6'(PS_4M));
      new_ent.asid  = lat_asid;
      new_ent.g     = bus.rf_g;
      new_ent.ppn   = bus.rf_ppn;
      new_ent.v     = bus.rf_v;
      new_ent.d     = bus.rf_d;
      new_ent.plv   = bus.rf_plv;
      new_ent.mat   = bus.rf_mat;
   end

   // entry storage: flush invalidates, refill installs into the victim
   always_ff @(posedge clk) begin
      if (reset) begin
         ents <= '0;
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) ents[i].valid <= 1'b0;
      end else if (install) begin
         ents[victim] <= new_ent;
      end
   end

   // FSM state, drop flag, request latch and replacement pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         drop     <= 1'b0;
         rr_ptr   <= '0;
         lat_va   <= '0;
         lat_asid <= '0;
      end else begin
         state <= nstate;
         if (idle_miss) begin
            lat_va   <= bus.lk_va[31:12];
            lat_asid <= asid;
         end
         if (install && full) rr_ptr <= rr_ptr + IDXW'(1);
         case (state)
            ST_REQ:  if (flush) drop <= 1'b1;
            ST_WAIT: if (bus.rf_rvalid) drop <= 1'b0;
                     else if (flush)    drop <= 1'b1;
            default: drop <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmu_utlb.sv
// Directed bench for mmu_utlb (ENTRIES=4): refill timing, huge pages,
// not-found, replacement, flush drop and reset mid-refill.
module tb_mmu_utlb;
   import mmu_utlb_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic [9:0] asid;
   int         checks = 0;
   int         failures = 0;

   mmu_utlb_if bus();

   mmu_utlb #(.ENTRIES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .asid  (asid),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] va;
      logic [9:0]  asid;
      logic        done;
      logic [31:0] pa;
      logic [5:0]  attr;   // {v, d, plv, mat}
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   // combinational lookup in IDLE; lk_valid drops before the edge so the FSM never sees it
   task automatic probe(input string nm, input logic [31:0] va, input logic [9:0] as,
                        input logic done, input logic [31:0] pa, input logic [5:0] attr);
      bus.lk_va = va; asid = as; bus.lk_valid = 1'b1;
      #1;
      chk({nm, "_done"}, 32'(bus.lk_done), 32'(done));
      chk({nm, "_found"}, 32'(bus.lk_found), 32'(done));
      chk({nm, "_pa"}, bus.lk_pa, pa);
      chk({nm, "_attr"}, 32'({bus.lk_v, bus.lk_d, bus.lk_plv, bus.lk_mat}), 32'(attr));
      #1 bus.lk_valid = 1'b0;
      cyc();
   endtask

   task automatic set_rsp(input logic fnd, input logic [19:0] ppn, input logic [5:0] ps,
                          input logic [5:0] attr, input logic g);
      bus.rf_found = fnd; bus.rf_ppn = ppn; bus.rf_ps = ps;
      bus.rf_v = attr[5]; bus.rf_d = attr[4]; bus.rf_plv = attr[3:2]; bus.rf_mat = attr[1:0];
      bus.rf_g = g;
   endtask

   // full miss/refill with grant in REQ and result one cycle later
   task automatic refill(input string nm, input logic [31:0] va, input logic [9:0] as,
                         input logic fnd, input logic [19:0] ppn, input logic [5:0] ps,
                         input logic [5:0] attr, input logic g, input logic [31:0] pa);
      bus.lk_va = va; asid = as; bus.lk_valid = 1'b1;
      #1 chk({nm, "_miss"}, 32'(bus.lk_done), 0);
      cyc();
      chk({nm, "_rf_req"}, 32'(bus.rf_req), 1);
      chk({nm, "_rf_vppn"}, 32'(bus.rf_vppn), 32'(va[31:13]));
      chk({nm, "_rf_bit12"}, 32'(bus.rf_va_bit12), 32'(va[12]));
      chk({nm, "_rf_asid"}, 32'(bus.rf_asid), 32'(as));
      bus.rf_gnt = 1'b1;
      cyc();
      bus.rf_gnt = 1'b0;
      bus.rf_rvalid = 1'b1;
      set_rsp(fnd, ppn, ps, attr, g);
      #1;
      chk({nm, "_rv_done"}, 32'(bus.lk_done), 32'(!fnd));
      chk({nm, "_rv_found"}, 32'(bus.lk_found), 0);
      cyc();
      bus.rf_rvalid = 1'b0;
      #1;
      chk({nm, "_done"}, 32'(bus.lk_done), 32'(fnd));
      if (fnd) chk({nm, "_pa"}, bus.lk_pa, pa);
      bus.lk_valid = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b0; asid = '0;
      bus.lk_valid = 1'b0; bus.lk_va = '0;
      bus.rf_gnt = 1'b0; bus.rf_rvalid = 1'b0;
      set_rsp(1'b0, '0, 6'd12, '0, 1'b0);
      cyc(); cyc();
      reset = 1'b0;
      #1;
      chk("rst_rf_req", 32'(bus.rf_req), 0);
      chk("rst_done", 32'(bus.lk_done), 0);
      chk("rst_found", 32'(bus.lk_found), 0);
      chk("rst_pa", bus.lk_pa, 0);
      cyc();

      // 4 KB refill, then a zero-latency repeat
      refill("t1", 32'h0040_1234, 10'd1, 1'b1, 20'h12345, 6'd12, 6'b1_0_00_01, 1'b0, 32'h1234_5234);
      probe("t1_rep", 32'h0040_1234, 10'd1, 1'b1, 32'h1234_5234, 6'b1_0_00_01);

      // 4 MB page, hit elsewhere in the page, then another ASID misses
      refill("t2", 32'h8000_0000, 10'd1, 1'b1, 20'h80000, 6'd21, 6'b1_1_11_01, 1'b0, 32'h8000_0000);
      probe("t2_huge", 32'h8012_3456, 10'd1, 1'b1, 32'h8012_3456, 6'b1_1_11_01);
      refill("t2_asid", 32'h8012_3456, 10'd2, 1'b0, 20'h0, 6'd12, 6'b0, 1'b0, 32'h0);

      // not found: done without install, so it misses again
      refill("t3", 32'h0050_0000, 10'd1, 1'b0, 20'h55555, 6'd12, 6'b1_1_11_11, 1'b0, 32'h0);
      probe("t3_again", 32'h0050_0000, 10'd1, 1'b0, 32'h0, 6'b0);

      // reset clears the array
      reset = 1'b1; cyc(); cyc(); reset = 1'b0;
      probe("rst_clear", 32'h0040_1234, 10'd1, 1'b0, 32'h0, 6'b0);

      // five installs into four entries; the fifth replaces entry 0
      for (int k = 0; k < 5; k++) begin
         logic [2:0]  kk;
         logic [31:0] va;
         logic [19:0] ppn;
         kk  = 3'(k);
         va  = 32'h1000_0000 + 32'(k) * 32'h2000;
         ppn = 20'h00100 + 20'(k);
         refill($sformatf("t4_ins%0d", k), va, 10'd1, 1'b1, ppn, 6'd12,
                {1'b1, kk[0], kk[1:0], 2'(kk + 3'd1)}, (k == 2), {ppn, 12'h000});
      end

      tbl[0] = '{"v_va1",   32'h1000_2ABC, 10'd1, 1'b1, 32'h0010_1ABC, 6'b1_1_01_10};
      tbl[1] = '{"v_va0",   32'h1000_0010, 10'd1, 1'b0, 32'h0,         6'b0};
      tbl[2] = '{"v_va4",   32'h1000_8FFF, 10'd1, 1'b1, 32'h0010_4FFF, 6'b1_0_00_01};
      tbl[3] = '{"v_glob",  32'h1000_4000, 10'd7, 1'b1, 32'h0010_2000, 6'b1_0_10_11};
      tbl[4] = '{"v_asid",  32'h1000_6000, 10'd7, 1'b0, 32'h0,         6'b0};
      tbl[5] = '{"v_odd",   32'h1000_7000, 10'd1, 1'b0, 32'h0,         6'b0};
      tbl[6] = '{"v_va3",   32'h1000_6000, 10'd1, 1'b1, 32'h0010_3000, 6'b1_1_11_00};
      for (int i = 0; i < 7; i++)
         probe(tbl[i].nm, tbl[i].va, tbl[i].asid, tbl[i].done, tbl[i].pa, tbl[i].attr);

      // flush in WAIT: response discarded, lookup re-misses and re-requests
      bus.lk_va = 32'h2000_0000; asid = 10'd1; bus.lk_valid = 1'b1;
      cyc();
      chk("t5_req1", 32'(bus.rf_req), 1);
      bus.rf_gnt = 1'b1;
      cyc();
      bus.rf_gnt = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      bus.rf_rvalid = 1'b1;
      set_rsp(1'b1, 20'h20000, 6'd12, 6'b1_0_01_01, 1'b0);
      #1 chk("t5_rv_done", 32'(bus.lk_done), 0);
      cyc();
      bus.rf_rvalid = 1'b0;
      #1 chk("t5_dropped", 32'(bus.lk_done), 0);
      cyc();
      #1 chk("t5_req2", 32'(bus.rf_req), 1);
      bus.rf_gnt = 1'b1;
      cyc();
      bus.rf_gnt = 1'b0; bus.rf_rvalid = 1'b1;
      cyc();
      bus.rf_rvalid = 1'b0;
      #1;
      chk("t5_done", 32'(bus.lk_done), 1);
      chk("t5_pa", bus.lk_pa, 32'h2000_0000);
      bus.lk_valid = 1'b0;
      cyc();
      probe("t5_flushed", 32'h1000_2000, 10'd1, 1'b0, 32'h0, 6'b0);

      // flush in IDLE: same-cycle lookup sees pre-flush contents
      bus.lk_va = 32'h2000_0000; asid = 10'd1; bus.lk_valid = 1'b1; flush = 1'b1;
      #1 chk("t5_idle_flush_hit", 32'(bus.lk_done), 1);
      #1 bus.lk_valid = 1'b0;
      cyc();
      flush = 1'b0;
      probe("t5_after_flush", 32'h2000_0000, 10'd1, 1'b0, 32'h0, 6'b0);

      // reset during WAIT
      refill("t6", 32'h3000_0000, 10'd1, 1'b1, 20'h30000, 6'd12, 6'b1_0_00_00, 1'b0, 32'h3000_0000);
      bus.lk_va = 32'h3000_2000; asid = 10'd1; bus.lk_valid = 1'b1;
      cyc();
      bus.rf_gnt = 1'b1;
      cyc();
      bus.rf_gnt = 1'b0; reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("t6_rf_req", 32'(bus.rf_req), 0);
      chk("t6_done", 32'(bus.lk_done), 0);
      bus.lk_valid = 1'b0;
      cyc();
      probe("t6_cleared", 32'h3000_0000, 10'd1, 1'b0, 32'h0, 6'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
